wm_menu_sel: RTL
================

Name: wm_menu_sel

Overview:
Parametrised washing-machine menu selector with NUM_ITEMS one-hot indicator LEDs. It takes raw left, right and OK buttons and provides debounce, auto-repeat on hold, and optional wrap-around. The selected item blinks while browsing and goes solid once OK locks it. It replaces the fixed 6-LED left/right selector in the panel top level and drives the panel buzzer with a timed key-click tone.

Parameters:
NUM_ITEMS, 6, number of menu items/LEDs (2..16)
CNT_1MSEC, 125000, clk cycles per 1 ms tick (even, >=4)
WRAP_EN, 1, 1 = index wraps at ends; 0 = index saturates at ends
DEBOUNCE_MS, 20, consecutive ms a button must be stable before its debounced level changes
REPEAT_DELAY_MS, 600, hold time from press event to first auto-repeat event
REPEAT_RATE_MS, 200, auto-repeat period after the first repeat
BLINK_HALF_MS, 500, blink on-time and off-time of the selected LED while unlocked
BUZ_MS, 50, buzzer burst length per accepted event

Ports:
clk  in  1  system clock, 125 MHz
reset  in  1  synchronous, active-high reset
but_in_left  in  1  raw left button, asynchronous, active-high
but_in_right  in  1  raw right button, asynchronous, active-high
but_in_ok  in  1  raw OK button, asynchronous, active-high
led_sel  out  NUM_ITEMS  one-hot LED drive, registered
sel_idx  out  IW=$clog2(NUM_ITEMS)  current index, registered
sel_locked  out  1  1 = selection confirmed
sel_valid  out  1  one-cycle pulse on lock
pwm_buzzer  out  1  buzzer square wave, registered

Behaviour:
- Reset values (synchronous, while reset=1): sel_idx=0, sel_locked=0, sel_valid=0, led_sel=1 (bit0 on, blink phase on), pwm_buzzer=0. All counters, synchronizers and debounced levels are cleared to 0.
- Timebase: a 1 ms counter counts 0..CNT_1MSEC-1.
  - tick_1ms pulses when count = CNT_1MSEC-1.
  - tick_half pulses when count = CNT_1MSEC/2-1 and when count = CNT_1MSEC-1.
- Button front end (one per button):
  - 2-flop synchronizer.
  - Debounce counter advances on tick_1ms while the synced value differs from the debounced level, and clears when they match.
  - The debounced level flips when the counter reaches DEBOUNCE_MS.
  - A press event is one clk pulse on a rising edge of the debounced level.
  - Release produces no event.
- Auto-repeat (left/right only; OK never repeats):
  - A hold counter runs on tick_1ms while the debounced level is 1.
  - A repeat event fires at REPEAT_DELAY_MS, then every REPEAT_RATE_MS after that.
  - The counter clears on release.
- Index update (the cycle after the event; sel_idx changes one clk after the event pulse):
  - Right: idx+1. Left: idx-1.
  - At idx = NUM_ITEMS-1 with right, or idx = 0 with left:
    - WRAP_EN=1: wrap to 0 or NUM_ITEMS-1 respectively.
    - WRAP_EN=0: hold the index and treat the move as rejected.
  - Left and right events in the same cycle: no move, no beep.
  - While sel_locked=1: left/right events are ignored (no move, no beep, repeat still counts internally).
- OK event:
  - Toggles sel_locked.
  - On the 0->1 transition, sel_valid pulses for exactly 1 cycle, in the same cycle sel_locked rises.
  - An OK event that coincides with a left/right event takes priority; the move is dropped.
- LED:
  - led_sel = one-hot(sel_idx) AND blink_on, registered, so it lags sel_idx by 1 clk.
  - Unlocked: blink_on toggles every BLINK_HALF_MS ms. The blink counter restarts with blink_on=1 on every index change and on unlock.
  - Locked: blink_on is forced to 1 (solid).
- Buzzer:
  - Accepted events (a move that changes or wraps the index, or OK) load a burst counter with BUZ_MS; it decrements on tick_1ms.
  - A new accepted event during a burst reloads the counter to BUZ_MS.
  - While the counter is nonzero, pwm_buzzer toggles on each tick_half (1 kHz tone at defaults).
  - pwm_buzzer is forced to 0 when the burst ends.
  - Rejected moves produce no beep.
- Reset asserted mid-operation (during a hold, blink or burst) returns every output to its reset value on the next clk. A button still held after reset release generates a fresh press event once debounced.
- Width rules: sel_idx never exceeds NUM_ITEMS-1; all ms counters are sized for their parameter without overflow.

Test Plan:
Bench setup for all scenarios: CNT_1MSEC=4, DEBOUNCE_MS=2, REPEAT_DELAY_MS=6, REPEAT_RATE_MS=3, BLINK_HALF_MS=4, BUZ_MS=3, NUM_ITEMS=6.
1. Assert reset 3 clks, release -> sel_idx=0, led_sel=6'b000001, pwm_buzzer=0, sel_locked=0. Pulse right for 1 clk only (bounce) -> no index change.
2. Hold right 40 ms from idx=0, WRAP_EN=1 -> one press event, then repeats at 6, 9, 12, ... ms. Index goes 1,2,3,4,5,0,... and wraps 5->0. Each step starts a 3 ms beep with pwm_buzzer toggling every 2 clks.
3. WRAP_EN=0, idx=0, press left -> sel_idx stays 0, no pwm_buzzer activity. Press right 5x then right again -> idx saturates at 5, and the last press gives no beep.
4. Press OK at idx=3 -> sel_locked=1, sel_valid high exactly 1 clk, led_sel=6'b001000 solid for >16 ms. Press left -> ignored. OK again -> unlocked, blinking resumes with 16-clk on phase.
5. Left and right press events in the same clk -> idx unchanged, no beep. Press OK and right in the same clk -> lock only, idx unchanged.
6. Assert reset mid-beep and mid-hold -> next clk all outputs at reset values. Right still held at release -> idx=1 after debounce plus 1 clk.

Source files
------------

// File: rtl/wm_menu_sel.sv
// Washing-machine menu selector: debounced left/right/OK buttons with auto-repeat,
// a blinking one-hot LED cursor, OK lock/unlock and a timed key-click buzzer.
module wm_menu_sel #(
  parameter int unsigned NUM_ITEMS       = 6,
  parameter int unsigned CNT_1MSEC       = 125000,
  parameter int unsigned WRAP_EN         = 1,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 600,
  parameter int unsigned REPEAT_RATE_MS  = 200,
  parameter int unsigned BLINK_HALF_MS   = 500,
  parameter int unsigned BUZ_MS          = 50
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         but_in_left,
  input  logic                         but_in_right,
  input  logic                         but_in_ok,
  output logic [NUM_ITEMS-1:0]         led_sel,
  output logic [$clog2(NUM_ITEMS)-1:0] sel_idx,
  output logic                         sel_locked,
  output logic                         sel_valid,
  output logic                         pwm_buzzer
);
  localparam int unsigned IW       = $clog2(NUM_ITEMS);
  localparam int unsigned CW       = $clog2(CNT_1MSEC);
  localparam int unsigned DW       = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int unsigned HW       = $clog2(HOLD_MAX + 1);
  localparam int unsigned BW       = $clog2(BLINK_HALF_MS + 1);
  localparam int unsigned ZW       = $clog2(BUZ_MS + 1);
  localparam int unsigned B_LEFT   = 0;
  localparam int unsigned B_RIGHT  = 1;
  localparam int unsigned B_OK     = 2;

  logic [CW-1:0]          ms_cnt_q, ms_cnt_d;
  logic [2:0]             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]             deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [2:0][DW-1:0]     deb_cnt_q, deb_cnt_d;
  logic [1:0][HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [1:0]             rep_ph_q, rep_ph_d;
  logic [IW-1:0]          sel_idx_q, sel_idx_d;
  logic                   locked_q, locked_d, valid_q, valid_d;
  logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
  logic                   blink_on_q, blink_on_d;
  logic [NUM_ITEMS-1:0]   led_q, led_d;
  logic [ZW-1:0]          buz_cnt_q, buz_cnt_d;
  logic                   pwm_q, pwm_d;

  logic                   tick_1ms_c, tick_half_c;
  logic [2:0]             press_c;
  logic [1:0]             rep_c;
  logic                   move_l_c, move_r_c, ok_c, accept_c;

  assign tick_1ms_c  = (ms_cnt_q == CW'(CNT_1MSEC - 1));
  assign tick_half_c = tick_1ms_c || (ms_cnt_q == CW'(CNT_1MSEC / 2 - 1));
  assign press_c     = deb_q & ~deb_prev_q;
  assign move_l_c    = press_c[B_LEFT] | rep_c[B_LEFT];
  assign move_r_c    = press_c[B_RIGHT] | rep_c[B_RIGHT];
  assign ok_c        = press_c[B_OK];

  // Timebase, synchronizers, debounce and auto-repeat hold counters
  always_comb begin
    ms_cnt_d   = tick_1ms_c ? '0 : ms_cnt_q + CW'(1);
    sync1_d    = {but_in_ok, but_in_right, but_in_left};
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rep_ph_d   = rep_ph_q;
    rep_c      = '0;
    for (int b = 0; b < 3; b++) begin
      if (sync2_q[b] == deb_q[b]) begin
        deb_cnt_d[b] = '0;
      end else if (tick_1ms_c) begin
        if (deb_cnt_q[b] == DW'(DEBOUNCE_MS - 1)) begin
          deb_d[b]     = ~deb_q[b];
          deb_cnt_d[b] = '0;
        end else begin
          deb_cnt_d[b] = deb_cnt_q[b] + DW'(1);
        end
      end
    end
    // First repeat after the delay, then one per rate period until release
    for (int b = 0; b < 2; b++) begin
      if (!deb_q[b]) begin
        hold_cnt_d[b] = '0;
        rep_ph_d[b]   = 1'b0;
      end else if (tick_1ms_c) begin
        if (hold_cnt_q[b] == (rep_ph_q[b] ? HW'(REPEAT_RATE_MS - 1) : HW'(REPEAT_DELAY_MS - 1))) begin
          rep_c[b]      = 1'b1;
          hold_cnt_d[b] = '0;
          rep_ph_d[b]   = 1'b1;
        end else begin
          hold_cnt_d[b] = hold_cnt_q[b] + HW'(1);
        end
      end
    end
  end

  // Menu index, lock, blink and buzzer
  always_comb begin
    sel_idx_d   = sel_idx_q;
    locked_d    = locked_q;
    valid_d     = 1'b0;
    accept_c    = 1'b0;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    buz_cnt_d   = buz_cnt_q;
    led_d       = blink_on_q ? (NUM_ITEMS'(1) << sel_idx_q) : '0;

    if (ok_c) begin
      locked_d = ~locked_q;
      valid_d  = ~locked_q;
      accept_c = 1'b1;
    end else if (!locked_q && (move_l_c ^ move_r_c)) begin
      if (move_r_c) begin
        if (sel_idx_q != IW'(NUM_ITEMS - 1)) begin
          sel_idx_d = sel_idx_q + IW'(1);
          accept_c  = 1'b1;
        end else if (WRAP_EN != 0) begin
          sel_idx_d = '0;
          accept_c  = 1'b1;
        end
      end else begin
        if (sel_idx_q != '0) begin
          sel_idx_d = sel_idx_q - IW'(1);
          accept_c  = 1'b1;
        end else if (WRAP_EN != 0) begin
          sel_idx_d = IW'(NUM_ITEMS - 1);
          accept_c  = 1'b1;
        end
      end
    end

    // Blink restarts in the on phase after any accepted event; solid while locked
    if (accept_c || locked_q) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (tick_1ms_c) begin
      if (blink_cnt_q == BW'(BLINK_HALF_MS - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    if (accept_c) begin
      buz_cnt_d = ZW'(BUZ_MS);
    end else if (tick_1ms_c && (buz_cnt_q != '0)) begin
      buz_cnt_d = buz_cnt_q - ZW'(1);
    end
    pwm_d = (buz_cnt_d == '0) ? 1'b0 : (pwm_q ^ tick_half_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_cnt_q    <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rep_ph_q    <= '0;
      sel_idx_q   <= '0;
      locked_q    <= 1'b0;
      valid_q     <= 1'b0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      led_q       <= NUM_ITEMS'(1);
      buz_cnt_q   <= '0;
      pwm_q       <= 1'b0;
    end else begin
      ms_cnt_q    <= ms_cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_prev_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_ph_q    <= rep_ph_d;
      sel_idx_q   <= sel_idx_d;
      locked_q    <= locked_d;
      valid_q     <= valid_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      led_q       <= led_d;
      buz_cnt_q   <= buz_cnt_d;
      pwm_q       <= pwm_d;
    end
  end

  assign led_sel    = led_q;
  assign sel_idx    = sel_idx_q;
  assign sel_locked = locked_q;
  assign sel_valid  = valid_q;
  assign pwm_buzzer = pwm_q;

endmodule
